dcache_snoop_responder: RTL
===========================

# dcache_snoop_responder

Cache-side end of the MSI snooping protocol: sits inside each dcache and answers the coherence controller's ccwait/ccinv/ccsnoopaddr. It looks up the snooped block in the dcache frame array and, on a dirty hit, supplies both words of the block over two bus handshakes. It then downgrades M->S, or invalidates the frame when ccinv is present. It also asserts snoop_busy so the cache's own FSM stalls while a snoop owns the frame array.

## Interface
Parameters
- SETS, 8, dcache sets; index width log2(SETS)
- WAYS, 2, associativity, fixed at 2

Ports
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- ccwait  in  1  controller holds this cache in snoop
- ccinv  in  1  invalidate the frame at ccsnoopaddr
- ccsnoopaddr  in  32  snooped word address
- dwait  in  1  bus wait for this cache; 0 = current snoop word accepted
- ccwrite  out  1  snoop hit on a Modified frame; data is on snoop_dstore
- snoop_dstore  out  32  snoop data word
- snoop_busy  out  1  responder owns frame array; cache FSM must hold
- rd_idx  out  log2(SETS)  frame-array read index (combinational from live or latched addr)
- rd_tag  in  2x26  tags of both ways at rd_idx
- rd_valid, rd_dirty  in  2x1 each  frame state bits
- rd_data  in  2x2x32  block words per way
- upd_en  out  1  one-cycle frame-state write strobe
- upd_way  out  1  way to update
- upd_valid, upd_dirty  out  1 each  new state bits
- link_set, link_clear  in  1 each  LL sets / SC clears link (LINK_SNOOP_EN only)
- link_addr_in  in  32  LL address (LINK_SNOOP_EN only)
- link_valid  out  1  link register valid (LINK_SNOOP_EN only)

## Operation
- Address split: tag[31:6], idx[5:3], blkoff[2], byteoff[1:0].
- Hit = rd_valid[w] && rd_tag[w]==tag, per way. Both ways hitting is illegal. The responder takes way 0 and flags it under an assertion.
- States: IDLE, SNOOP0, SNOOP1.
- IDLE:
  - On ccwait=1: latch ccsnoopaddr and the hit way; latch dirty_hit = hit && dirty; go to SNOOP0.
  - On ccinv=1 with ccwait=0 and a hit: upd_en=1, valid=0, dirty=0; stay in IDLE. This is the write-miss-clean, no-owner path.
- SNOOP0:
  - ccwrite = dirty_hit.
  - If dirty_hit: snoop_dstore = word0. On dwait=0 go to SNOOP1.
  - If not dirty_hit: on ccinv=1 with a latched hit, invalidate and go to IDLE. Otherwise, when ccwait=0 and ccinv=0, go to IDLE with no update. Else hold in SNOOP0.
- SNOOP1:
  - ccwrite=1, snoop_dstore = word1.
  - On dwait=0, apply the update and go to IDLE:
    - ccinv=1: invalidate (valid=0, dirty=0).
    - ccinv=0: downgrade (valid=1, dirty=0).
  - ccinv is sampled in the same cycle as dwait=0.
- snoop_busy = (state != IDLE) || ccwait || ccinv.

## Timing
- Reset: state=IDLE, latched addr=0, ccwrite=0, snoop_dstore=0, upd_en=0, snoop_busy=0, link_valid=0.
- ccwait at edge N: ccwrite and word0 are valid combinationally in cycle N+1.
- Each word is held until the first cycle with dwait=0. A stall of any length is legal.
- upd_en is a single cycle, in the cycle the final handshake completes.
- rd_idx uses ccsnoopaddr in IDLE and the latched address otherwise.
- Reset mid-snoop: back to IDLE immediately with no frame update. The controller is reset in the same cycle.
- ccinv in IDLE together with a cache-side upd request: the responder wins, because the cache FSM is stalled by snoop_busy.

## Configuration
- LINK_SNOOP_EN defined:
  - A link register is held here. link_set loads link_addr_in with valid=1; link_clear clears it.
  - Any invalidate (IDLE or SNOOP path) whose block address, bits [31:3], matches the link clears link_valid. This clear wins over a simultaneous link_set.
- LINK_SNOOP_EN undefined: link ports are absent, link_valid is tied 0, and there is no link logic.

## Structure
- Shared package dcache_coh_pkg:
  - dcachef_t (tag/idx/blkoff/byteoff)
  - snoop_state_t
  - TAG_W=26, IDX_W=3
  - frame-state bit definitions
- Sub-module snoop_tag_match: combinational two-way tag compare returning hit, way and dirty.

## Test plan
- Dirty hit, read snoop:
  - Stimulus: frame idx2 way1 holds tag 0x40, dirty, data {0xAAAA0000, 0xBBBB1111}; ccwait at 0x1010; dwait low one cycle per word.
  - Response: ccwrite=1; snoop_dstore 0xAAAA0000 then 0xBBBB1111; then upd valid=1, dirty=0.
- Dirty hit with invalidate: same setup, ccinv=1 in SNOOP1 -> frame ends valid=0, dirty=0.
- Clean hit, invalidate without ccwait: ccinv alone at a matching address -> upd_en for one cycle, valid=0; state stays IDLE; ccwrite=0.
- Miss: ccwait at 0x2000 with no matching tag -> ccwrite=0; no upd_en; return to IDLE once ccwait drops.
- Stall: dwait held high for 5 cycles in SNOOP0 -> word0 stable throughout; SNOOP1 only after dwait=0.
- LINK_SNOOP_EN: LL to 0x1014, then ccinv at 0x1010 -> link_valid drops the next cycle; RST mid-SNOOP1 -> all outputs 0 with no update.

Source files
------------

// File: rtl/dcache_coh_pkg.sv
// Shared types for the dcache coherence (MSI snoop) path.
// Address split, snoop FSM states and frame-state bit encodings.
// Optional LL/SC link tracking in the responder is enabled by LINK_SNOOP_EN.
package dcache_coh_pkg;

  localparam int TAG_W  = 26;
  localparam int IDX_W  = 3;
  localparam int WORD_W = 32;
  localparam int BLK_W  = TAG_W + IDX_W;

  // Word address as seen by the dcache: tag | set index | word-in-block | byte.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       byteoff;
  } dcachef_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNOOP0 = 2'd1,
    SNOOP1 = 2'd2
  } snoop_state_t;

  // MSI state of one frame as stored in the frame array.
  typedef struct packed {
    logic valid;
    logic dirty;
  } frame_state_t;

  localparam frame_state_t FS_INVALID  = '{valid: 1'b0, dirty: 1'b0};
  localparam frame_state_t FS_SHARED   = '{valid: 1'b1, dirty: 1'b0};
  localparam frame_state_t FS_MODIFIED = '{valid: 1'b1, dirty: 1'b1};

  // Block address (everything above the word-in-block bit).
  function automatic logic [BLK_W-1:0] blk_addr(input dcachef_t a);
    return {a.tag, a.idx};
  endfunction

endpackage

// File: rtl/dcache_snoop_responder_match.sv
// snoop_tag_match: two-way tag compare for the snooped set.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever rd_* the frame array presents.
module snoop_tag_match
  import dcache_coh_pkg::*;
(
  input  logic [TAG_W-1:0]      tag,
  input  logic [1:0][TAG_W-1:0] rd_tag,
  input  logic [1:0]            rd_valid,
  input  logic [1:0]            rd_dirty,
  output logic                  hit,
  output logic                  way,
  output logic                  dirty,
  output logic                  multi_hit
);

  logic [1:0] way_hit;

  // Per-way hit, way 0 preferred should both ways ever claim the block.
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = rd_valid[w] && (rd_tag[w] == tag);
    end
    hit       = |way_hit;
    way       = !way_hit[0] && way_hit[1];
    dirty     = hit && rd_dirty[way];
    multi_hit = &way_hit;
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder: answers controller snoops, supplies dirty blocks, downgrades/invalidates.
// Latency: word0 valid the cycle after ccwait is sampled; update strobe on the final handshake.
// Backpressure: each snoop word is held until dwait=0; snoop_busy stalls the cache FSM.
// Optional feature macro: LINK_SNOOP_EN (LL/SC link register cleared by matching invalidates).
module dcache_snoop_responder
  import dcache_coh_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ccwait,
  input  logic                             ccinv,
  input  logic [31:0]                      ccsnoopaddr,
  input  logic                             dwait,
  output logic                             ccwrite,
  output logic [31:0]                      snoop_dstore,
  output logic                             snoop_busy,
  output logic [$clog2(SETS)-1:0]          rd_idx,
  input  logic [WAYS-1:0][TAG_W-1:0]       rd_tag,
  input  logic [WAYS-1:0]                  rd_valid,
  input  logic [WAYS-1:0]                  rd_dirty,
  input  logic [WAYS-1:0][1:0][WORD_W-1:0] rd_data,
  output logic                             upd_en,
  output logic                             upd_way,
  output logic                             upd_valid,
  output logic                             upd_dirty,
`ifdef LINK_SNOOP_EN
  input  logic                             link_set,
  input  logic                             link_clear,
  input  logic [31:0]                      link_addr_in,
`endif
  output logic                             link_valid
);

  snoop_state_t state, next_state;

  dcachef_t     live_addr;
  dcachef_t     snoop_addr;
  dcachef_t     cur_addr;

  // Snoop context captured when ccwait is accepted.
  logic         snoop_way;
  logic         snoop_hit;
  logic         snoop_dirty;

  logic         m_hit;
  logic         m_way;
  logic         m_dirty;
  logic         m_multi;

  logic         upd_req;
  frame_state_t upd_state;

  // In IDLE the frame array is indexed by the live snoop address so the
  // ccinv-only path and the ccwait capture see the right set this cycle.
  assign live_addr = dcachef_t'(ccsnoopaddr);
  assign cur_addr  = (state == IDLE) ? live_addr : snoop_addr;
  assign rd_idx    = cur_addr.idx;

  snoop_tag_match u_match (
    .tag       (cur_addr.tag),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .hit       (m_hit),
    .way       (m_way),
    .dirty     (m_dirty),
    .multi_hit (m_multi)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture address and lookup result when a snoop is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snoop_addr  <= '0;
      snoop_way   <= 1'b0;
      snoop_hit   <= 1'b0;
      snoop_dirty <= 1'b0;
    end else if ((state == IDLE) && ccwait) begin
      snoop_addr  <= live_addr;
      snoop_way   <= m_way;
      snoop_hit   <= m_hit;
      snoop_dirty <= m_dirty;
    end
  end

  // Next-state: dirty snoops walk both words, clean snoops wait for the controller.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (ccwait) begin
          next_state = SNOOP0;
        end
      end
      SNOOP0: begin
        if (snoop_dirty) begin
          if (!dwait) begin
            next_state = SNOOP1;
          end
        end else if (ccinv && snoop_hit) begin
          next_state = IDLE;
        end else if (!ccwait && !ccinv) begin
          next_state = IDLE;
        end
      end
      SNOOP1: begin
        if (!dwait) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: snoop data, ccwrite and the single-cycle frame update request.
  always_comb begin
    ccwrite      = 1'b0;
    snoop_dstore = '0;
    upd_req      = 1'b0;
    upd_state    = FS_INVALID;
    upd_way      = snoop_way;
    unique case (state)
      IDLE: begin
        // Write-miss on a clean copy with no owner: invalidate in place.
        upd_way = m_way;
        if (!ccwait && ccinv && m_hit) begin
          upd_req = 1'b1;
        end
      end
      SNOOP0: begin
        if (snoop_dirty) begin
          ccwrite      = 1'b1;
          snoop_dstore = rd_data[snoop_way][0];
        end else if (ccinv && snoop_hit) begin
          upd_req = 1'b1;
        end
      end
      SNOOP1: begin
        ccwrite      = 1'b1;
        snoop_dstore = rd_data[snoop_way][1];
        if (!dwait) begin
          upd_req   = 1'b1;
          upd_state = ccinv ? FS_INVALID : FS_SHARED;
        end
      end
      default: ;
    endcase
  end

  // A reset arriving mid-snoop must not leave a half-finished frame update behind.
  assign upd_en     = upd_req && !RST;
  assign upd_valid  = upd_state.valid;
  assign upd_dirty  = upd_state.dirty;
  assign snoop_busy = (state != IDLE) || ccwait || ccinv;

`ifdef LINK_SNOOP_EN
  logic [BLK_W-1:0] link_blk;
  logic             link_vld;
  logic             inv_fire;
  logic             inv_kills_link;

  assign inv_fire       = upd_en && !upd_valid;
  // An invalidate of the linked block breaks the LL/SC pair, even one being set this cycle.
  assign inv_kills_link = inv_fire &&
                          ((link_vld && (blk_addr(cur_addr) == link_blk)) ||
                           (link_set && (blk_addr(cur_addr) == link_addr_in[31:3])));

  // Link register: snoop invalidate beats LL set, LL set beats SC clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_blk <= '0;
      link_vld <= 1'b0;
    end else begin
      if (link_set) begin
        link_blk <= link_addr_in[31:3];
      end
      if (inv_kills_link) begin
        link_vld <= 1'b0;
      end else if (link_set) begin
        link_vld <= 1'b1;
      end else if (link_clear) begin
        link_vld <= 1'b0;
      end
    end
  end

  assign link_valid = link_vld;

  logic unused_link_bits;
  assign unused_link_bits = ^link_addr_in[2:0];
`else
  assign link_valid = 1'b0;
`endif

  // Word/byte offsets never matter for a block-granular snoop.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr.blkoff, cur_addr.byteoff, m_multi};

  // Both ways holding the snooped tag means the frame array is corrupt.
  assert property (@(posedge CLK) disable iff (RST) snoop_busy |-> !m_multi)
    else $error("snoop_tag_match: both ways hit");

endmodule
